// File: rtl/fetch_pipe_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pipe_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam int unsigned FETCH_PC_STEP = 4;

    function automatic logic [31:0] perf_sat_inc(input logic [31:0] value, input logic en);
        return (en && (value != '1)) ? value + 32'd1 : value;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush; head is read straight from registered storage
// and forced to zero while empty.
module fetch_fifo #(
    parameter type         T     = logic [31:0],
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    output T                       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    T              mem_q [DEPTH];
    T              mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = empty ? '0 : mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fetch_pipe.sv
// Instruction-fetch stage: PC, pipelined imem requests, fetch queue, redirect flush.
// Optional perf counters (fetched/discarded/starved) are enabled by FETCH_PERF_CNT_EN.
module fetch_pipe
    import fetch_pipe_pkg::*;
#(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int unsigned      DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_pc,
    output logic [XLEN-1:0] inst_data
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_discarded,
    output logic [31:0]     perf_starved
`endif
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = CW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } entry_t;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;

    logic [CW-1:0]   q_count;
    logic            q_full, q_empty;
    entry_t          q_head, q_push_data;
    logic [XLEN-1:0] pcf_head;
    logic [CW-1:0]   pcf_count;
    logic            pcf_full, pcf_empty;
    logic [SW-1:0]   inflight;
    logic            req_fire, rsp_drop, rsp_keep, deq;

    // Requests in flight plus queued entries never exceed DEPTH, so a write always fits.
    assign inflight       = {1'b0, outstanding_q} + {1'b0, q_count};
    assign imem_req_valid = !rst && !redirect_valid && (inflight < SW'(DEPTH));
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_drop = imem_rsp_valid && (redirect_valid || (discard_q != '0));
    assign rsp_keep = imem_rsp_valid && !rsp_drop;

    assign inst_valid = !rst && !redirect_valid && !q_empty;
    assign inst_pc    = q_head.pc;
    assign inst_data  = q_head.inst;
    assign deq        = inst_valid && inst_ready;

    assign q_push_data = '{pc: pcf_head, inst: imem_rsp_data};

    fetch_fifo #(.T(logic [XLEN-1:0]), .DEPTH(DEPTH)) u_pc_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (req_fire),
        .push_data (pc_q),
        .pop       (rsp_keep),
        .head      (pcf_head),
        .full      (pcf_full),
        .empty     (pcf_empty),
        .count     (pcf_count)
    );

    fetch_fifo #(.T(entry_t), .DEPTH(DEPTH)) u_inst_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (rsp_keep),
        .push_data (q_push_data),
        .pop       (deq),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    logic unused_fifo_status;
    assign unused_fifo_status = ^{pcf_full, pcf_empty, pcf_count, q_full};

    always_comb begin
        pc_d          = pc_q;
        discard_d     = discard_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
        if (redirect_valid) begin
            pc_d = redirect_pc;
            // Nothing issues in a redirect cycle, so every request still in flight
            // after this cycle is stale: discard becomes the next outstanding count.
            discard_d = outstanding_d;
        end else begin
            if (req_fire) begin
                pc_d = pc_q + XLEN'(FETCH_PC_STEP);
            end
            if (imem_rsp_valid && (discard_q != '0)) begin
                discard_d = discard_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_discarded_q, perf_discarded_d;
    logic [31:0] perf_starved_q, perf_starved_d;

    always_comb begin
        perf_fetched_d   = perf_sat_inc(perf_fetched_q, rsp_keep);
        perf_discarded_d = perf_sat_inc(perf_discarded_q, rsp_drop);
        perf_starved_d   = perf_sat_inc(perf_starved_q, inst_ready && !inst_valid);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q   <= '0;
            perf_discarded_q <= '0;
            perf_starved_q   <= '0;
        end else begin
            perf_fetched_q   <= perf_fetched_d;
            perf_discarded_q <= perf_discarded_d;
            perf_starved_q   <= perf_starved_d;
        end
    end

    assign perf_fetched   = perf_fetched_q;
    assign perf_discarded = perf_discarded_q;
    assign perf_starved   = perf_starved_q;
`endif

endmodule

// File: tb/tb_fetch_pipe.sv
// Self-checking bench for fetch_pipe: behavioural memory, expected-instruction queue,
// cycle table for reset/backpressure, and directed redirect sequences.
module tb_fetch_pipe;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] SIG   = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_discarded, perf_starved;
`endif

    fetch_pipe #(.XLEN(XLEN), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_pc        (inst_pc),
        .inst_data      (inst_data)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_discarded (perf_discarded),
        .perf_starved   (perf_starved)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
        int unsigned epoch;
    } mem_req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    typedef struct {
        logic        inst_ready;
        logic        req_valid;
        logic [31:0] req_addr;
        logic        inst_valid;
        logic [31:0] inst_pc;
    } vec_t;

    mem_req_t    pend[$];
    exp_t        exp_q[$];
    int unsigned cyc, lat, epoch, rsp_epoch;
    logic [31:0] exp_pc;
    int unsigned mdl_fetched, mdl_dropped, mdl_starved, n_hs;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Mid-cycle: record handshakes, score deliveries, track redirects.
    task automatic observe();
        exp_t e;
        @(negedge clk);
        if (rst) return;
        if (redirect_valid) begin
            chk("redir_no_req", {31'b0, imem_req_valid}, 32'd0);
            chk("redir_no_inst", {31'b0, inst_valid}, 32'd0);
        end
        if (imem_rsp_valid) begin
            if (rsp_epoch != epoch || redirect_valid) mdl_dropped++;
            else mdl_fetched++;
        end
        if (inst_ready && !inst_valid) mdl_starved++;
        if (inst_valid && inst_ready) begin
            n_hs++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL stale_inst: got inst_pc %h required no valid entry (cycle %0d)", inst_pc, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("inst_pc", inst_pc, e.pc);
                chk("inst_data", inst_data, e.inst);
            end
        end
        if (imem_req_valid && imem_req_ready) begin
            chk("req_addr", imem_req_addr, exp_pc);
            pend.push_back('{imem_req_addr, cyc + lat, epoch});
            exp_q.push_back('{exp_pc, exp_pc ^ SIG});
            exp_pc = exp_pc + 32'd4;
        end
        if (redirect_valid) begin
            epoch++;
            exp_q.delete();
            exp_pc = redirect_pc;
        end
    endtask

    // Just after the edge: start a new cycle and present the memory response.
    task automatic advance();
        logic     rst_at_edge;
        mem_req_t m;
        @(posedge clk);
        rst_at_edge = rst;
        #1;
        cyc++;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (rst_at_edge) begin
            pend.delete();
            exp_q.delete();
            epoch++;
            exp_pc      = 32'h0;
            cyc         = 0;
            mdl_fetched = 0;
            mdl_dropped = 0;
            mdl_starved = 0;
        end else if (pend.size() > 0 && pend[0].due <= cyc) begin
            m = pend.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = m.addr ^ SIG;
            rsp_epoch      = m.epoch;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        inst_ready = 1'b0;
        imem_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
            chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
            if (i > 0) begin
                chk("rst_inst_pc", inst_pc, 32'd0);
                chk("rst_inst_data", inst_data, 32'd0);
            end
            advance();
        end
        rst = 1'b0;
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic check_perf();
        chk("perf_fetched", perf_fetched, mdl_fetched);
        chk("perf_discarded", perf_discarded, mdl_dropped);
        chk("perf_starved", perf_starved, mdl_starved);
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got time %0t required completion before 1000000", $time);
        $fatal(1);
    end

    initial begin
        vec_t        tbl[12];
        int          first;
        int unsigned rcyc, hs0;

        // Reset, backpressure with inst_ready=0, then drain and resume (1-cycle memory).
        tbl[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h0};
        tbl[3]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h0};
        tbl[4]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h0};
        tbl[5]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h0};
        tbl[6]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h0};
        tbl[7]  = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h0};
        tbl[8]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h4};
        tbl[9]  = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h8};
        tbl[10] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'hC};
        tbl[11] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};

        cyc = 0; epoch = 0; rsp_epoch = 0; n_hs = 0;
        exp_pc = 32'h0; lat = 1;
        mdl_fetched = 0; mdl_dropped = 0; mdl_starved = 0;

        do_reset();
`ifdef FETCH_PERF_CNT_EN
        check_perf();
`endif
        for (int i = 0; i < 12; i++) begin
            inst_ready = tbl[i].inst_ready;
            observe();
            chk("tbl_req_valid", {31'b0, imem_req_valid}, {31'b0, tbl[i].req_valid});
            chk("tbl_req_addr", imem_req_addr, tbl[i].req_addr);
            chk("tbl_inst_valid", {31'b0, inst_valid}, {31'b0, tbl[i].inst_valid});
            chk("tbl_inst_pc", inst_pc, tbl[i].inst_pc);
            advance();
        end

        for (int i = 0; i < 20; i++) begin
            observe();
            chk("stream_valid", {31'b0, inst_valid}, 32'd1);
            advance();
        end

        // Redirect with three requests in flight on a 3-cycle memory.
        do_reset();
        lat = 3;
        inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            observe();
            advance();
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        observe();
        advance();
        redirect_valid = 1'b0;
        observe();
        chk("redir_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("redir_req_addr", imem_req_addr, 32'h100);
        advance();
        first = -1;
        for (int i = 0; i < 16; i++) begin
            observe();
            if (inst_valid && first < 0) begin
                first = int'(cyc);
                chk("redir_first_pc", inst_pc, 32'h100);
            end
            advance();
        end
        chk("redir_first_cycle", first, 32'd8);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_discarded_3", perf_discarded, 32'd3);
        check_perf();
`endif

        // Back-to-back redirects: only the second target's stream survives.
        do_reset();
        lat = 1;
        inst_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            observe();
            advance();
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        observe();
        advance();
        redirect_pc = 32'h300;
        rcyc = cyc;
        observe();
        advance();
        redirect_valid = 1'b0;
        observe();
        chk("dbl_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("dbl_req_addr", imem_req_addr, 32'h300);
        advance();
        first = -1;
        for (int i = 0; i < 15; i++) begin
            observe();
            if (inst_valid && first < 0) begin
                first = int'(cyc);
                chk("dbl_first_pc", inst_pc, 32'h300);
            end
            advance();
        end
        chk("dbl_first_cycle", first, rcyc + 3);
`ifdef FETCH_PERF_CNT_EN
        check_perf();
`endif

        // Random backpressure, memory stalls and redirects.
        lat = 2;
        for (int i = 0; i < 300; i++) begin
            inst_ready = 1'($urandom_range(0, 1));
            imem_req_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc = $urandom & 32'hFFFF_FFFC;
            observe();
            advance();
        end
        redirect_valid = 1'b0;
        inst_ready = 1'b1;
        imem_req_ready = 1'b1;
        hs0 = n_hs;
        for (int i = 0; i < 30; i++) begin
            observe();
            advance();
        end
        chk("drain_progress", {31'b0, (n_hs - hs0) >= 20}, 32'd1);
`ifdef FETCH_PERF_CNT_EN
        check_perf();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
